// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit adder/subtractor: one C-bit carry chunk resolved per stage, valid/ready flow.
// Optional ovf/zero flag outputs are built only when PIPE_ADD_FLAGS_EN is defined.
module pipelined_add_sub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_ADD_FLAGS_EN
  ,
  output logic             ovf,
  output logic             zero
`endif
);

  localparam int C = WIDTH / STAGES;

  if (WIDTH % STAGES != 0) begin : g_bad_cfg
    $error("pipelined_add_sub: WIDTH must be a multiple of STAGES");
  end

  // Handshake: a beat moves on a rising edge when valid & ready. The whole pipe advances
  // together whenever the output slot is empty or being drained, so in_ready = adv.
  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // RW = operand bits still unprocessed when entering stage k; the low C of them are added here.
    localparam int RW = WIDTH - k * C;

    logic                 src_v;
    logic                 src_c;
    logic [RW-1:0]        src_a;
    logic [RW-1:0]        src_b;
    logic [C:0]           chunk;
    logic [(k+1)*C-1:0]   s_next;

    logic                 v_q;
    logic                 c_q;
    logic [(k+1)*C-1:0]   s_q;

    if (k == 0) begin : g_src
      assign src_v  = in_valid;
      assign src_a  = a;
      assign src_b  = sub ? ~b : b;
      assign src_c  = sub | cin;
      assign s_next = chunk[C-1:0];
    end else begin : g_src
      assign src_v  = g_stage[k-1].v_q;
      assign src_a  = g_stage[k-1].g_fwd.a_q;
      assign src_b  = g_stage[k-1].g_fwd.b_q;
      assign src_c  = g_stage[k-1].c_q;
      assign s_next = {chunk[C-1:0], g_stage[k-1].s_q};
    end

    assign chunk = {1'b0, src_a[C-1:0]} + {1'b0, src_b[C-1:0]} + {{C{1'b0}}, src_c};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= src_v;
        c_q <= chunk[C];
        s_q <= s_next;
      end
    end

    // Upper operand chunks ride along, skewed, until their stage consumes them.
    if (k < STAGES - 1) begin : g_fwd
      logic [RW-C-1:0] a_q;
      logic [RW-C-1:0] b_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= src_a[RW-1:C];
          b_q <= src_b[RW-1:C];
        end
      end
    end

`ifdef PIPE_ADD_FLAGS_EN
    if (k == STAGES - 1) begin : g_flags
      logic ovf_q;
      logic zero_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv) begin
          ovf_q  <= (src_a[RW-1] == src_b[RW-1]) & (chunk[C-1] != src_a[RW-1]);
          zero_q <= ~|s_next;
        end
      end
    end
`endif
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].s_q;
  assign cout      = g_stage[STAGES-1].c_q;
`ifdef PIPE_ADD_FLAGS_EN
  assign ovf       = g_stage[STAGES-1].g_flags.ovf_q;
  assign zero      = g_stage[STAGES-1].g_flags.zero_q;
`endif

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Scoreboarded bench for pipelined_add_sub (WIDTH=32, STAGES=4) with hand-computed vectors.
// Flag outputs are compared only when PIPE_ADD_FLAGS_EN is defined.
module tb_pipelined_add_sub;
  localparam int W = 32;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
`ifdef PIPE_ADD_FLAGS_EN
  logic         ovf;
  logic         zero;
`endif

  pipelined_add_sub #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef PIPE_ADD_FLAGS_EN
    , .ovf(ovf), .zero(zero)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    logic         z;
  } vec_t;

  vec_t          vt[12];
  logic [W+2:0]  exp_q[$];   // {zero, ovf, cout, sum}
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Monitor: compares the head of the queue whenever a result is presented; pops on transfer.
  always @(negedge clk) begin
    logic [W+2:0] got;
    logic [W+2:0] want;
    if (!rst && out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got sum=%h cout=%b want none", sum, cout);
      end else begin
`ifdef PIPE_ADD_FLAGS_EN
        got  = {zero, ovf, cout, sum};
        want = exp_q[0];
`else
        got  = {2'b00, cout, sum};
        want = {2'b00, exp_q[0][W:0]};
`endif
        if (got !== want) begin
          errors++;
          $display("FAIL result got {z,ov,co,sum}=%h want %h", got, want);
        end
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Caller starts at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int i);
    logic ok;
    logic accepted;
    in_valid = 1'b1;
    a   = vt[i].a;
    b   = vt[i].b;
    cin = vt[i].cin;
    sub = vt[i].sub;
    accepted = 1'b0;
    for (int t = 0; t < 50 && !accepted; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      if (ok) accepted = 1'b1;
    end
    if (accepted) exp_q.push_back({vt[i].z, vt[i].ov, vt[i].co, vt[i].s});
    else chk("send_timeout", 64'(accepted), 64'd1);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    //          a             b             cin   sub   sum           co    ov    z
    vt[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vt[1]  = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vt[4]  = '{32'h12345678, 32'h00000000, 1'b0, 1'b1, 32'h12345678, 1'b1, 1'b0, 1'b0};
    vt[5]  = '{32'h00000001, 32'h00000001, 1'b1, 1'b0, 32'h00000003, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000007, 1'b1, 1'b0, 1'b0};
    vt[7]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vt[8]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    vt[9]  = '{32'h00000005, 32'h00000005, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vt[10] = '{32'h00FF00FF, 32'h00010001, 1'b0, 1'b0, 32'h01000100, 1'b0, 1'b0, 1'b0};
    vt[11] = '{32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};

    // Reset state, observed while rst is held.
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_sum", 64'(sum), 64'd0);
    chk("reset_cout", 64'(cout), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    #2 rst = 1'b0;

    // Single beat: latency in edges from the accepting edge, then the trailing bubble.
    @(posedge clk); #1;
    send(0);
    n = 1;
    while (n < 20) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      n++;
    end
    chk("latency", 64'(n), 64'(S));
    @(posedge clk);
    @(negedge clk);
    chk("bubble_out_valid", 64'(out_valid), 64'd0);

    // The other hand-computed cases, back to back.
    @(posedge clk); #1;
    for (int i = 1; i < 4; i++) send(i);
    drain();

    // 8-beat stream with a 3-cycle downstream stall once results start appearing.
    @(posedge clk); #1;
    fork
      for (int i = 4; i < 12; i++) send(i);
      begin
        for (int t = 0; t < 40 && !out_valid; t++) @(negedge clk);
        @(posedge clk); #2 out_ready = 1'b0;
        for (int t = 0; t < 3; t++) begin
          @(negedge clk);
          chk("stall_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #2 out_ready = 1'b1;
      end
    join
    drain();

    // Three beats in flight with output held, then an asynchronous reset pulse.
    @(posedge clk); #2 out_ready = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) send(i);
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_sum", 64'(sum), 64'd0);
    chk("midreset_cout", 64'(cout), 64'd0);
    exp_q.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    n = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("no_stale_output", 64'(n), 64'd0);

    // Pipe still works after the reset.
    @(posedge clk); #1;
    send(3);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
